// File: rtl/cpu_step_ctrl_pkg.sv
// Shared definitions for the run/step sequencer: state encodings and a width helper.
package cpu_step_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_RUN  = 2'b01,
        ST_STEP = 2'b10,
        ST_BRK  = 2'b11
    } state_t;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/cpu_step_ctrl_btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability counter, debounced level
// and a one-cycle pulse on each accepted 0->1 transition.
module btn_debounce
    import cpu_step_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic rise_o
);

    localparam int unsigned CW = cnt_width(DEBOUNCE_CYCLES);

    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          rise_q, rise_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b00;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    // The counter only runs while the synchronized input disagrees with the
    // accepted level; any agreement restarts the stability window.
    always_comb begin
        sync_d  = {sync_q[0], btn_i};
        cnt_d   = cnt_q;
        level_d = level_q;
        rise_d  = 1'b0;
        if (sync_q[1] == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            cnt_d   = '0;
            level_d = sync_q[1];
            rise_d  = sync_q[1];
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/cpu_step_ctrl.sv
// Run/step sequencer producing the CPU clock-enable. Define BREAKPOINT_EN to
// build the PC breakpoint comparator and the BRK state.
module cpu_step_ctrl
    import cpu_step_ctrl_pkg::*;
#(
    parameter int unsigned RATE_DIV        = 10_000_000,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned PC_W            = 32,
    parameter int unsigned CNT_W           = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run_i,
    input  logic             step_btn_i,
    input  logic [PC_W-1:0]  pc_i,
    input  logic [PC_W-1:0]  bp_addr_i,
    output logic             cpu_ce_o,
    output logic [1:0]       state_o,
    output logic             halted_o,
    output logic [CNT_W-1:0] instr_cnt_o
);

    localparam int unsigned TW = cnt_width(RATE_DIV);

    state_t           state_q, state_d;
    logic             ce_q, ce_d;
    logic             halted_q, halted_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TW-1:0]    tick_q, tick_d;
    logic             step_pulse;
    logic             tick_wrap;
    logic             bp_hit;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn (
        .clk    (clk),
        .rst_n  (rst_n),
        .btn_i  (step_btn_i),
        .rise_o (step_pulse)
    );

`ifdef BREAKPOINT_EN
    assign bp_hit = (pc_i == bp_addr_i);
`else
    logic unused_pc;
    assign unused_pc = ^{pc_i, bp_addr_i};
    assign bp_hit    = 1'b0;
`endif

    assign tick_wrap = (tick_q == TW'(RATE_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_HALT;
            ce_q     <= 1'b0;
            halted_q <= 1'b1;
            cnt_q    <= '0;
            tick_q   <= '0;
        end else begin
            state_q  <= state_d;
            ce_q     <= ce_d;
            halted_q <= halted_d;
            cnt_q    <= cnt_d;
            tick_q   <= tick_d;
        end
    end

    // Dropping run_i beats both a due ce and a breakpoint hit.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HALT: begin
                if (run_i)           state_d = ST_RUN;
                else if (step_pulse) state_d = ST_STEP;
            end
            ST_RUN: begin
                if (!run_i)                  state_d = ST_HALT;
                else if (tick_wrap && bp_hit) state_d = ST_BRK;
            end
            ST_STEP: state_d = ST_HALT;
            ST_BRK: begin
                if (!run_i)          state_d = ST_HALT;
                else if (step_pulse) state_d = ST_STEP;
            end
            default: state_d = ST_HALT;
        endcase
    end

    always_comb begin
        ce_d   = 1'b0;
        tick_d = '0;
        if (state_q == ST_RUN && run_i) begin
            if (tick_wrap) ce_d   = !bp_hit;
            else           tick_d = tick_q + TW'(1);
        end
        if (state_d == ST_STEP) ce_d = 1'b1;
        cnt_d    = ce_d ? cnt_q + CNT_W'(1) : cnt_q;
        halted_d = (state_d == ST_HALT) || (state_d == ST_BRK);
    end

    assign cpu_ce_o    = ce_q;
    assign state_o     = state_q;
    assign halted_o    = halted_q;
    assign instr_cnt_o = cnt_q;

endmodule
